knapsack_search_ctrl: RTL
=========================

Name: knapsack_search_ctrl

Overview:
- Sequential exhaustive-search controller for the multi-constraint knapsack feasibility datapath. Items have value, weight and volume; limits are a minimum total value, a maximum total weight and a maximum total volume.
- Holds a programmable item/limit table and enumerates every item subset, one per cycle, through an internal two-stage evaluate/compare pipeline.
- Reports the best feasible subset, its value, and the number of feasible subsets.
- Sits between a host/config master and downstream consumers of the selection result.

Parameters:
- N_ITEMS, 5, number of items; subsets enumerated = 2^N_ITEMS.
- W, 32, width of every value/weight/volume/limit entry.
- IDX_W, 3, width of cfg_item; must satisfy 2^IDX_W >= N_ITEMS and IDX_W >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- cfg_we  input  1  config write strobe.
- cfg_field  input  2  0=item value, 1=item weight, 2=item volume, 3=limit.
- cfg_item  input  IDX_W  item index for fields 0-2; for field 3: 0=min_value, 1=max_weight, 2=max_volume.
- cfg_data  input  W  write data.
- start  input  1  request a search.
- busy  output  1  search in progress.
- done  output  1  one-cycle pulse; results valid.
- found  output  1  at least one feasible subset.
- best_mask  output  N_ITEMS  best subset; bit i = item i selected.
- best_value  output  W+N_ITEMS  total value of best_mask.
- valid_count  output  N_ITEMS+1  number of feasible subsets.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All outputs go to 0.
  - FSM goes to IDLE.
  - All table entries and limits go to 0.
  - Reset mid-search aborts immediately; no done pulse is produced.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE: start=1 at an edge -> SCAN. At that edge: busy<=1, found/best_mask/best_value/valid_count<=0, mask counter<=0.
  - SCAN: issues mask counter value k into stage 1 each cycle, then increments. After issuing mask 2^N_ITEMS-1 -> DRAIN.
  - DRAIN: 2 cycles, flushing stages 1 and 2. Then busy<=0, done<=1 for exactly one cycle -> IDLE.
- Latency: done is high in cycle start_edge + 2^N_ITEMS + 2 (34 for N_ITEMS=5). Results are stable from done until the next accepted start.
- Stage 1 (registered):
  - Sums value, weight and volume of the selected items at W+N_ITEMS bits, unsigned; no wrap is possible.
  - Carries the mask alongside the sums.
- Stage 2 (registered): computes feasible = (sum_value >= min_value) && (sum_weight <= max_weight) && (sum_volume <= max_volume), unsigned, with limits zero-extended.
  - If feasible: valid_count increments.
  - If feasible and (found==0 or sum_value > best_value): found<=1, best_mask<=mask, best_value<=sum_value.
  - Ties keep the earlier (lower) mask. Mask 0 is a legal candidate.
- Config:
  - Writes apply only when busy=0; cfg_we while busy is ignored, so the table is frozen during a search.
  - Writes with cfg_field=3 and cfg_item>2 are ignored, as are item indices >= N_ITEMS.
  - A write and a start in the same IDLE cycle: the write lands first and the search uses the new value.
- start while busy is ignored; it is not queued.
- start held high continuously: a new search begins the cycle after done (back-to-back).
- valid_count may reach 2^N_ITEMS; its width covers this.

Test Plan:
- Load values 4,2,2,1,10; weights 12,1,2,1,4; volumes 1,1,1,1,1; min_value=15, max_weight=16, max_volume=10. Pulse start -> done at cycle 34, found=1, best_mask=5'h1E, best_value=15, valid_count=1.
- Same table with min_value=20 -> found=0, best_mask=0, best_value=0, valid_count=0, done still at cycle 34.
- Tie-break: all values=1, weights=1, volumes=1, min_value=0, max_weight=1, max_volume=10 -> best_mask=5'h01, best_value=1, valid_count=6.
- Wide sums: all weights=32'hFFFFFFFF, max_weight=32'hFFFFFFFF, values 1..5, min_value=0, max_volume=10 -> no wrap, best_mask=5'h10, best_value=5, valid_count=6.
- Protocol: mid-search, issue start and a cfg_we changing min_value -> both ignored, results identical to the first scenario.
- Robustness, in sequence:
  - Assert rst_n=0 at cycle 10 of a search -> next cycle all outputs 0, no done pulse, table cleared.
  - Reload the table and hold start high -> consecutive done pulses 35 cycles apart, results repeat.

Source files
------------

// File: rtl/knapsack_search_ctrl.sv
// knapsack_search_ctrl: exhaustive subset search over a programmable
// item/limit table. One subset is issued per cycle into a two-stage
// evaluate/compare pipeline; best feasible subset and feasible count reported.
module knapsack_search_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int W       = 32,
  parameter int IDX_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_field,
  input  logic [IDX_W-1:0]     cfg_item,
  input  logic [W-1:0]         cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [N_ITEMS-1:0]   best_mask,
  output logic [W+N_ITEMS-1:0] best_value,
  output logic [N_ITEMS:0]     valid_count
);

  localparam int SW = W + N_ITEMS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Item table and limits
  logic [W-1:0] val_q [N_ITEMS];
  logic [W-1:0] val_d [N_ITEMS];
  logic [W-1:0] wgt_q [N_ITEMS];
  logic [W-1:0] wgt_d [N_ITEMS];
  logic [W-1:0] vol_q [N_ITEMS];
  logic [W-1:0] vol_d [N_ITEMS];
  logic [W-1:0] min_value_q, min_value_d;
  logic [W-1:0] max_weight_q, max_weight_d;
  logic [W-1:0] max_volume_q, max_volume_d;

  // Control
  logic [1:0]         state_q, state_d;
  logic [N_ITEMS-1:0] cnt_q, cnt_d;
  logic               drain_q, drain_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Stage 1 registers
  logic               s1_valid_q, s1_valid_d;
  logic [N_ITEMS-1:0] s1_mask_q, s1_mask_d;
  logic [SW-1:0]      s1_val_q, s1_val_d;
  logic [SW-1:0]      s1_wgt_q, s1_wgt_d;
  logic [SW-1:0]      s1_vol_q, s1_vol_d;

  // Results (stage 2)
  logic               found_q, found_d;
  logic [N_ITEMS-1:0] best_mask_q, best_mask_d;
  logic [SW-1:0]      best_value_q, best_value_d;
  logic [N_ITEMS:0]   valid_count_q, valid_count_d;
  logic               feasible;

  // Config writes, accepted only while idle
  always_comb begin
    val_d        = val_q;
    wgt_d        = wgt_q;
    vol_d        = vol_q;
    min_value_d  = min_value_q;
    max_weight_d = max_weight_q;
    max_volume_d = max_volume_q;
    if (cfg_we && !busy_q) begin
      if (cfg_field == 2'd3) begin
        if (cfg_item == IDX_W'(0)) min_value_d  = cfg_data;
        if (cfg_item == IDX_W'(1)) max_weight_d = cfg_data;
        if (cfg_item == IDX_W'(2)) max_volume_d = cfg_data;
      end else begin
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
          if (cfg_item == IDX_W'(i)) begin
            if (cfg_field == 2'd0) val_d[i] = cfg_data;
            if (cfg_field == 2'd1) wgt_d[i] = cfg_data;
            if (cfg_field == 2'd2) vol_d[i] = cfg_data;
          end
        end
      end
    end
  end

  // Stage 1: sum the attributes of the subset selected by the mask counter
  always_comb begin
    s1_valid_d = (state_q == ST_SCAN);
    s1_mask_d  = cnt_q;
    s1_val_d   = '0;
    s1_wgt_d   = '0;
    s1_vol_d   = '0;
    for (int unsigned i = 0; i < N_ITEMS; i++) begin
      if (cnt_q[i]) begin
        s1_val_d = s1_val_d + SW'(val_q[i]);
        s1_wgt_d = s1_wgt_d + SW'(wgt_q[i]);
        s1_vol_d = s1_vol_d + SW'(vol_q[i]);
      end
    end
  end

  assign feasible = (s1_val_q >= SW'(min_value_q)) &&
                    (s1_wgt_q <= SW'(max_weight_q)) &&
                    (s1_vol_q <= SW'(max_volume_q));

  // Sequencing FSM plus stage 2 compare/update; start clears results and
  // no stage-1 entry is valid in IDLE, so the two never collide
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    best_mask_d   = best_mask_q;
    best_value_d  = best_value_q;
    valid_count_d = valid_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_SCAN;
          busy_d        = 1'b1;
          cnt_d         = '0;
          found_d       = 1'b0;
          best_mask_d   = '0;
          best_value_d  = '0;
          valid_count_d = '0;
        end
      end
      ST_SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (s1_valid_q && feasible) begin
      valid_count_d = valid_count_q + 1'b1;
      if (!found_q || (s1_val_q > best_value_q)) begin
        found_d      = 1'b1;
        best_mask_d  = s1_mask_q;
        best_value_d = s1_val_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) begin
        val_q[i] <= '0;
        wgt_q[i] <= '0;
        vol_q[i] <= '0;
      end
      min_value_q   <= '0;
      max_weight_q  <= '0;
      max_volume_q  <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      drain_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_mask_q     <= '0;
      s1_val_q      <= '0;
      s1_wgt_q      <= '0;
      s1_vol_q      <= '0;
      found_q       <= 1'b0;
      best_mask_q   <= '0;
      best_value_q  <= '0;
      valid_count_q <= '0;
    end else begin
      val_q         <= val_d;
      wgt_q         <= wgt_d;
      vol_q         <= vol_d;
      min_value_q   <= min_value_d;
      max_weight_q  <= max_weight_d;
      max_volume_q  <= max_volume_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      s1_valid_q    <= s1_valid_d;
      s1_mask_q     <= s1_mask_d;
      s1_val_q      <= s1_val_d;
      s1_wgt_q      <= s1_wgt_d;
      s1_vol_q      <= s1_vol_d;
      found_q       <= found_d;
      best_mask_q   <= best_mask_d;
      best_value_q  <= best_value_d;
      valid_count_q <= valid_count_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign best_mask   = best_mask_q;
  assign best_value  = best_value_q;
  assign valid_count = valid_count_q;

endmodule
